// File: rtl/alu_issue_pkg.sv
// Shared types, encodings and the combinational decoder for alu_issue_unit.
// ALU_ISSUE_RV32M_EN adds the MUL state and the iterative-multiply decode path.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_SLL  = 6'd2,
    ALU_SLT  = 6'd3,
    ALU_SLTU = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_OR   = 6'd8,
    ALU_AND  = 6'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_ZERO = 2'd1,
    A_SEL_PC   = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
`ifdef ALU_ISSUE_RV32M_EN
    ST_DONE = 2'd2,
    ST_MUL  = 2'd3
`else
    ST_DONE = 2'd2
`endif
  } issue_state_e;

  typedef struct packed {
    alu_ctrl_e ctrl;
    a_sel_e    a_sel;
    logic      b_imm;
    logic      illegal;
`ifdef ALU_ISSUE_RV32M_EN
    logic      is_mul;
`endif
  } decode_t;

  function automatic alu_ctrl_e base_op(input logic [2:0] funct3);
    alu_ctrl_e c;
    case (funct3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  function automatic decode_t decode(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
    decode_t d;
    d.ctrl    = ALU_ADD;
    d.a_sel   = A_SEL_RS1;
    d.b_imm   = 1'b0;
    d.illegal = 1'b0;
`ifdef ALU_ISSUE_RV32M_EN
    d.is_mul  = 1'b0;
`endif
    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_BASE) begin
          d.ctrl = base_op(funct3);
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          d.ctrl = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          d.ctrl = ALU_SRA;
`ifdef ALU_ISSUE_RV32M_EN
        end else if (funct7 == FUNCT7_MULDIV && funct3 == 3'b000) begin
          d.is_mul = 1'b1;
`endif
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // funct7 overlaps the immediate, so it only matters for the shifts
        d.b_imm = 1'b1;
        d.ctrl  = base_op(funct3);
        if (funct3 == 3'b101) begin
          if (funct7 == FUNCT7_ALT)       d.ctrl = ALU_SRA;
          else if (funct7 != FUNCT7_BASE) d.illegal = 1'b1;
        end else if (funct3 == 3'b001 && funct7 != FUNCT7_BASE) begin
          d.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d.a_sel = A_SEL_ZERO;
        d.b_imm = 1'b1;
      end
      OPC_AUIPC: begin
        d.a_sel = A_SEL_PC;
        d.b_imm = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) d.ctrl = ALU_ADD;
    return d;
  endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles after start,
// returning the low W bits of the product with a one-cycle done pulse.
module alu_iter_mul #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  acc_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        cnt_q    <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/alu_issue_unit.sv
// Execute-stage issuer: decodes one RV32I ALU op per handshake, drives the external ALU,
// returns its result with rd. ALU_ISSUE_RV32M_EN enables the iterative MUL path.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rd,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic [XLEN-1:0]   operand_A,
  output logic [XLEN-1:0]   operand_B,
  input  logic [XLEN-1:0]   ALU_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // valid never waits on ready, and payloads are held stable while valid && !ready.

  issue_state_e    state_q, state_d;
  decode_t         dec;
  logic            accept;
  logic            load_alu;
  logic [XLEN-1:0] op_a_sel, op_b_sel;
  alu_ctrl_e       ctrl_q;
  logic [4:0]      rd_q;
  logic            illegal_q;

  assign dec      = decode(in_opcode, in_funct3, in_funct7);
  assign in_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept   = in_valid && in_ready;
  assign ALU_Control = CTRL_W'(ctrl_q);

`ifdef ALU_ISSUE_RV32M_EN
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

  assign load_alu = accept && !dec.is_mul;

  alu_iter_mul #(.W(XLEN)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept && dec.is_mul),
    .a       (in_rs1_data),
    .b       (in_rs2_data),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign load_alu = accept;
`endif

  always_comb begin
    op_a_sel = in_rs1_data;
    op_b_sel = dec.b_imm ? in_imm : in_rs2_data;
    case (dec.a_sel)
      A_SEL_ZERO: op_a_sel = '0;
      A_SEL_PC:   op_a_sel = in_pc;
      default:    op_a_sel = in_rs1_data;
    endcase
    if (dec.illegal) begin
      op_a_sel = '0;
      op_b_sel = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_ISSUE_RV32M_EN
          state_d = dec.is_mul ? ST_MUL : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
`ifdef ALU_ISSUE_RV32M_EN
      ST_MUL:  if (mul_done && !mul_busy) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ALU-facing registers only change on a non-MUL accept; they hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= ALU_ADD;
      operand_A <= '0;
      operand_B <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (load_alu) begin
        ctrl_q    <= dec.ctrl;
        operand_A <= op_a_sel;
        operand_B <= op_b_sel;
      end
      if (accept) begin
        rd_q      <= in_rd;
        illegal_q <= dec.illegal;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data    <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      out_data    <= illegal_q ? '0 : ALU_result;
      out_rd      <= rd_q;
      out_illegal <= illegal_q;
`ifdef ALU_ISSUE_RV32M_EN
    end else if (state_q == ST_MUL && mul_done) begin
      out_data    <= mul_product;
      out_rd      <= rd_q;
      out_illegal <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU on the ALU_* side.
// Covers ALU_ISSUE_RV32M_EN builds too (MUL latency/result or MUL-as-illegal).
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 1 + 5 + XLEN;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      in_opcode = '0;
  logic [2:0]      in_funct3 = '0;
  logic [6:0]      in_funct7 = '0;
  logic [XLEN-1:0] in_rs1_data = '0;
  logic [XLEN-1:0] in_rs2_data = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic [4:0]      in_rd = '0;
  logic [5:0]      ALU_Control;
  logic [XLEN-1:0] operand_A;
  logic [XLEN-1:0] operand_B;
  logic [XLEN-1:0] ALU_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_illegal;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clock = ~clock;

  // behavioural ALU the unit drives
  always_comb begin
    ALU_result = '0;
    case (ALU_Control)
      6'd0: ALU_result = operand_A + operand_B;
      6'd1: ALU_result = operand_A - operand_B;
      6'd2: ALU_result = operand_A << operand_B[4:0];
      6'd3: ALU_result = ($signed(operand_A) < $signed(operand_B)) ? 32'd1 : 32'd0;
      6'd4: ALU_result = (operand_A < operand_B) ? 32'd1 : 32'd0;
      6'd5: ALU_result = operand_A ^ operand_B;
      6'd6: ALU_result = operand_A >> operand_B[4:0];
      6'd7: ALU_result = $signed(operand_A) >>> operand_B[4:0];
      6'd8: ALU_result = operand_A | operand_B;
      6'd9: ALU_result = operand_A & operand_B;
      default: ALU_result = '0;
    endcase
  end

  alu_issue_unit #(.XLEN(XLEN), .CTRL_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7   (in_funct7),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .ALU_Control (ALU_Control),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .ALU_result  (ALU_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic set_inputs(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
  endtask

  // Drives one non-MUL op through the full handshake with `hold` cycles of backpressure.
  task automatic drive_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [5:0] e_ctrl, input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [31:0] e_data, input logic e_ill, input int hold);
    int n;
    logic [W-1:0] exp_v;
    set_inputs(opc, f3, f7, rs1, rs2, imm, pc, rd);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    exp_q.push_back({e_ill, rd, e_data});
    checks++;
    if ({ALU_Control, operand_A, operand_B, in_ready, out_valid} !== {e_ctrl, e_a, e_b, 2'b00}) begin
      errors++;
      $display("FAIL %s exec ctrl=%h A=%h B=%h rdy=%b vld=%b required ctrl=%h A=%h B=%h rdy=0 vld=0",
               name, ALU_Control, operand_A, operand_B, in_ready, out_valid, e_ctrl, e_a, e_b);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency out_valid=%b required 1", name, out_valid);
    end
    exp_v = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      set_inputs(OPC_OP, 3'b000, 7'b0, 32'h1, 32'h1, 32'h0, 32'h0, 5'd1);
      in_valid = 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({out_valid, in_ready, out_illegal, out_rd, out_data, ALU_Control} !== {2'b10, exp_v, e_ctrl}) begin
        errors++;
        $display("FAIL %s hold%0d vld=%b rdy=%b ill=%b rd=%0d data=%h ctrl=%h required vld=1 rdy=0 result=%h ctrl=%h",
                 name, i, out_valid, in_ready, out_illegal, out_rd, out_data, ALU_Control, exp_v, e_ctrl);
      end
    end
    checks++;
    if ({out_illegal, out_rd, out_data} !== exp_v) begin
      errors++;
      $display("FAIL %s result ill=%b rd=%0d data=%h required %h", name, out_illegal, out_rd, out_data, exp_v);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, ALU_Control, operand_A, operand_B} !== {2'b01, e_ctrl, e_a, e_b}) begin
      errors++;
      $display("FAIL %s release vld=%b rdy=%b ctrl=%h A=%h B=%h required vld=0 rdy=1 ctrl=%h A=%h B=%h",
               name, out_valid, in_ready, ALU_Control, operand_A, operand_B, e_ctrl, e_a, e_b);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    set_inputs(OPC_OP, 3'b000, 7'b0, 32'h5, 32'h5, 32'h0, 32'h0, 5'd2);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, out_illegal, ALU_Control, operand_A, operand_B, out_data, out_rd} !== {3'b100, 6'd0, 96'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b ill=%b ctrl=%h A=%h B=%h data=%h rd=%0d required rdy=1 rest 0",
               in_ready, out_valid, out_illegal, ALU_Control, operand_A, operand_B, out_data, out_rd);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, ALU_Control} !== {2'b10, 6'd0}) begin
      errors++;
      $display("FAIL reset_release rdy=%b vld=%b ctrl=%h required rdy=1 vld=0 ctrl=0", in_ready, out_valid, ALU_Control);
    end
  endtask

  task automatic test_plan_ops();
    drive_op("op_add", OPC_OP, 3'b000, 7'b0, 32'h5, 32'h3, $urandom, $urandom, 5'd7,
             6'd0, 32'h5, 32'h3, 32'h8, 1'b0, 0);
    drive_op("srai", OPC_OP_IMM, 3'b101, 7'b0100000, 32'hFFFFFFF0, $urandom, 32'h4, $urandom, 5'd9,
             6'd7, 32'hFFFFFFF0, 32'h4, 32'hFFFFFFFF, 1'b0, 0);
    drive_op("auipc", OPC_AUIPC, 3'b000, 7'b0, $urandom, $urandom, 32'h8, 32'hFFFFFFFC, 5'd1,
             6'd0, 32'hFFFFFFFC, 32'h8, 32'h4, 1'b0, 0);
    drive_op("lui", OPC_LUI, 3'b101, 7'b0, $urandom, $urandom, 32'h12345000, $urandom, 5'd31,
             6'd0, 32'h0, 32'h12345000, 32'h12345000, 1'b0, 0);
    drive_op("illegal_opc", 7'b0000011, 3'b010, 7'b0, $urandom, $urandom, $urandom, $urandom, 5'd12,
             6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_decode();
    logic [31:0] a, b, m;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; m = $urandom_range(0, 31);
      if (i == 0) b = m;
      drive_op("sub", OPC_OP, 3'b000, FUNCT7_ALT, a, b, 32'h0, 32'h0, 5'd3, 6'd1, a, b, a - b, 1'b0, 0);
      drive_op("sll", OPC_OP, 3'b001, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd4, 6'd2, a, b, a << b[4:0], 1'b0, 0);
      drive_op("slt", OPC_OP, 3'b010, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd5, 6'd3, a, b,
               ($signed(a) < $signed(b)) ? 32'd1 : 32'd0, 1'b0, 0);
      drive_op("sltu", OPC_OP, 3'b011, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd6, 6'd4, a, b,
               (a < b) ? 32'd1 : 32'd0, 1'b0, 0);
      drive_op("srl", OPC_OP, 3'b101, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd8, 6'd6, a, b, a >> b[4:0], 1'b0, 0);
      drive_op("or", OPC_OP, 3'b110, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd10, 6'd8, a, b, a | b, 1'b0, 0);
      drive_op("and", OPC_OP, 3'b111, FUNCT7_BASE, a, b, 32'h0, 32'h0, 5'd11, 6'd9, a, b, a & b, 1'b0, 0);
      drive_op("addi_neg", OPC_OP_IMM, 3'b000, 7'b1111111, a, b, 32'hFFFFF800, 32'h0, 5'd13,
               6'd0, a, 32'hFFFFF800, a + 32'hFFFFF800, 1'b0, 0);
      drive_op("sltiu", OPC_OP_IMM, 3'b011, 7'b0, a, b, m, 32'h0, 5'd14, 6'd4, a, m, (a < m) ? 32'd1 : 32'd0, 1'b0, 0);
      drive_op("xori", OPC_OP_IMM, 3'b100, 7'b0, a, b, m, 32'h0, 5'd15, 6'd5, a, m, a ^ m, 1'b0, 0);
    end
    drive_op("op_bad_f7", OPC_OP, 3'b000, 7'b0000010, 32'h7, 32'h7, 32'h0, 32'h0, 5'd16, 6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    drive_op("op_alt_f3", OPC_OP, 3'b001, FUNCT7_ALT, 32'h7, 32'h7, 32'h0, 32'h0, 5'd17, 6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    drive_op("slli_bad", OPC_OP_IMM, 3'b001, FUNCT7_ALT, 32'h7, 32'h7, 32'h1, 32'h0, 5'd18, 6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    drive_op("srli_bad", OPC_OP_IMM, 3'b101, 7'b0000100, 32'h7, 32'h7, 32'h1, 32'h0, 5'd19, 6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    drive_op("backpressure", OPC_OP, 3'b100, FUNCT7_BASE, 32'h0000FF00, 32'h00FF00FF, 32'h0, 32'h0, 5'd20,
             6'd5, 32'h0000FF00, 32'h00FF00FF, 32'h00FFFFFF, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    int n_acc, n_out;
    logic [W-1:0] exp_v;
    n_acc = 0; n_out = 0;
    set_inputs(OPC_OP, 3'b000, FUNCT7_BASE, $urandom, $urandom, 32'h0, 32'h0, 5'd21);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        n_out++;
        exp_v = exp_q.pop_front();
        checks++;
        if ({out_illegal, out_rd, out_data} !== exp_v) begin
          errors++;
          $display("FAIL b2b_result%0d got=%h required %h", n_out, {out_illegal, out_rd, out_data}, exp_v);
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back({1'b0, in_rd, in_rs1_data + in_rs2_data});
      end
      @(posedge clock); #1;
      if (n_acc > 0 && c % 3 == 0) in_rs1_data = $urandom;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 4 || n_out !== 4) begin
      errors++;
      $display("FAIL b2b_throughput accepts=%0d results=%0d required 4 and 4", n_acc, n_out);
    end
  endtask

  task automatic test_reset_mid();
    set_inputs(OPC_OP, 3'b000, FUNCT7_BASE, 32'h9, 32'h9, 32'h0, 32'h0, 5'd22);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, ALU_Control, operand_A} !== {1'b0, 6'd0, 32'h9}) begin
      errors++;
      $display("FAIL rst_mid_exec rdy=%b ctrl=%h A=%h required rdy=0 ctrl=0 A=9", in_ready, ALU_Control, operand_A);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_illegal, ALU_Control, operand_A, operand_B, out_data, out_rd} !== {3'b100, 6'd0, 96'd0, 5'd0}) begin
      errors++;
      $display("FAIL rst_mid_clear rdy=%b vld=%b ctrl=%h A=%h B=%h data=%h rd=%0d required rdy=1 rest 0",
               in_ready, out_valid, ALU_Control, operand_A, operand_B, out_data, out_rd);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL rst_mid_stale%0d vld=%b rdy=%b required vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

`ifdef ALU_ISSUE_RV32M_EN
  task automatic drive_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_data, input logic [4:0] rd);
    logic [W-1:0] exp_v;
    set_inputs(OPC_OP, 3'b000, FUNCT7_MULDIV, a, b, 32'h0, 32'h0, rd);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    exp_q.push_back({1'b0, rd, e_data});
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) begin
        @(posedge clock); #1;
      end
      if (k == 1 || k == 32) begin
        checks++;
        if ({out_valid, in_ready, ALU_Control, operand_A, operand_B} !== {2'b00, 6'd5, 32'h0000F0F0, 32'h00000FF0}) begin
          errors++;
          $display("FAIL %s busy%0d vld=%b rdy=%b ctrl=%h A=%h B=%h required vld=0 rdy=0 ALU held at 05/F0F0/0FF0",
                   name, k, out_valid, in_ready, ALU_Control, operand_A, operand_B);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency out_valid=%b required 1", name, out_valid);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({out_illegal, out_rd, out_data} !== exp_v) begin
      errors++; $display("FAIL %s result got=%h required %h", name, {out_illegal, out_rd, out_data}, exp_v);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s release vld=%b rdy=%b required vld=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_mul();
    drive_op("pre_mul_xor", OPC_OP, 3'b100, FUNCT7_BASE, 32'h0000F0F0, 32'h00000FF0, 32'h0, 32'h0, 5'd2,
             6'd5, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 0);
    drive_mul("mul_wrap", 32'h00010000, 32'h00010000, 32'h00000000, 5'd23);
    drive_mul("mul_small", 32'd7, 32'd6, 32'd42, 5'd24);
    drive_mul("mul_neg", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 5'd25);
    drive_op("mulh_illegal", OPC_OP, 3'b001, FUNCT7_MULDIV, 32'h3, 32'h3, 32'h0, 32'h0, 5'd26,
             6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
  endtask
`else
  task automatic test_mul();
    drive_op("mul_illegal", OPC_OP, 3'b000, FUNCT7_MULDIV, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 5'd23,
             6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_plan_ops();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_mul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete by 200000");
    $fatal(1, "watchdog");
  end

endmodule
